// File: rtl/spi_pixel_rx_pkg.sv
// Shared definitions for the SPI pixel receiver: opcode, byte width, FSM state type
// and the saturating increment used by the optional error counter.
package spi_pixel_rx_pkg;

   localparam logic [7:0] CMD_WRITE = 8'h01;
   localparam int         BYTE_W    = 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CMD     = 3'd1,
      ADDR_HI = 3'd2,
      ADDR_LO = 3'd3,
      DATA    = 3'd4,
      DISCARD = 3'd5
   } state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      if (v == 16'hFFFF) begin
         return v;
      end else begin
         return v + 16'd1;
      end
   endfunction

endpackage

// File: rtl/spi_pixel_rx_sync.sv
// spi_sync: 2-flop synchronisers for SCLK/SS/MOSI plus SCLK-rise and SS-edge detection.
// SS falls are only reported once SS has been seen high after reset.
module spi_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sclk_i,
   input  logic ss_i,
   input  logic mosi_i,
   output logic sclk_rise_o,
   output logic ss_fall_o,
   output logic ss_rise_o,
   output logic mosi_o
);

   logic       sclk_meta_q, sclk_sync_q, sclk_prev_q;
   logic       sclk_meta_d, sclk_sync_d, sclk_prev_d;
   logic       ss_meta_q, ss_sync_q, ss_prev_q;
   logic       ss_meta_d, ss_sync_d, ss_prev_d;
   logic       mosi_meta_q, mosi_sync_q;
   logic       mosi_meta_d, mosi_sync_d;
   logic [1:0] vld_q, vld_d;
   logic       armed_q, armed_d;

   // Next values for the synchroniser chains; vld marks when ss_sync holds real samples.
   always_comb begin
      sclk_meta_d = sclk_i;
      sclk_sync_d = sclk_meta_q;
      sclk_prev_d = sclk_sync_q;
      ss_meta_d   = ss_i;
      ss_sync_d   = ss_meta_q;
      ss_prev_d   = ss_sync_q;
      mosi_meta_d = mosi_i;
      mosi_sync_d = mosi_meta_q;
      vld_d       = {vld_q[0], 1'b1};
      armed_d     = armed_q | (vld_q[1] & ss_sync_q);
   end

   // Synchroniser flops, reset to the idle bus levels.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         sclk_meta_q <= 1'b0;
         sclk_sync_q <= 1'b0;
         sclk_prev_q <= 1'b0;
         ss_meta_q   <= 1'b1;
         ss_sync_q   <= 1'b1;
         ss_prev_q   <= 1'b1;
         mosi_meta_q <= 1'b0;
         mosi_sync_q <= 1'b0;
         vld_q       <= 2'b00;
         armed_q     <= 1'b0;
      end else begin
         sclk_meta_q <= sclk_meta_d;
         sclk_sync_q <= sclk_sync_d;
         sclk_prev_q <= sclk_prev_d;
         ss_meta_q   <= ss_meta_d;
         ss_sync_q   <= ss_sync_d;
         ss_prev_q   <= ss_prev_d;
         mosi_meta_q <= mosi_meta_d;
         mosi_sync_q <= mosi_sync_d;
         vld_q       <= vld_d;
         armed_q     <= armed_d;
      end
   end

   assign sclk_rise_o = sclk_sync_q & ~sclk_prev_q;
   assign ss_fall_o   = armed_q & ss_prev_q & ~ss_sync_q;
   assign ss_rise_o   = ss_sync_q & ~ss_prev_q;
   assign mosi_o      = mosi_sync_q;

endmodule

// File: rtl/spi_pixel_rx.sv
// SPI mode-0 slave that turns "01 AH AL D0 D1 ..." transactions into framebuffer writes.
// Optional macro SPI_PIXEL_RX_STATS_EN adds a saturating 16-bit error counter err_cnt_o.
module spi_pixel_rx
   import spi_pixel_rx_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              spi_sclk_i,
   input  logic              spi_ss_i,
   input  logic              spi_mosi_i,
   output logic              fb_wr_o,
   output logic [ADDR_W-1:0] fb_addr_o,
   output logic [DATA_W-1:0] fb_data_o,
   output logic              busy_o
`ifdef SPI_PIXEL_RX_STATS_EN
   ,
   output logic [15:0]       err_cnt_o
`endif
);

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic              sclk_rise_s, ss_fall_s, ss_rise_s, mosi_s;
   logic              byte_done_s;
   logic [7:0]        byte_s;

   state_t            state_q, state_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [6:0]        shift_q, shift_d;
   logic [7:0]        addr_hi_q, addr_hi_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              fb_wr_q, fb_wr_d;
   logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
   logic [DATA_W-1:0] fb_data_q, fb_data_d;
   logic              busy_q, busy_d;

   spi_sync u_sync (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .sclk_i      (spi_sclk_i),
      .ss_i        (spi_ss_i),
      .mosi_i      (spi_mosi_i),
      .sclk_rise_o (sclk_rise_s),
      .ss_fall_o   (ss_fall_s),
      .ss_rise_o   (ss_rise_s),
      .mosi_o      (mosi_s)
   );

   assign byte_s      = {shift_q, mosi_s};
   assign byte_done_s = (state_q != IDLE) && sclk_rise_s && (bit_cnt_q == 3'd7);

   // State register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; SS rising wins over any byte-driven transition.
   always_comb begin
      state_d = state_q;
      if (state_q == IDLE) begin
         if (ss_fall_s) begin
            state_d = CMD;
         end else begin
            state_d = IDLE;
         end
      end else if (ss_rise_s) begin
         state_d = IDLE;
      end else if (byte_done_s) begin
         case (state_q)
            CMD:     state_d = (byte_s == CMD_WRITE) ? ADDR_HI : DISCARD;
            ADDR_HI: state_d = ADDR_LO;
            ADDR_LO: state_d = DATA;
            DATA:    state_d = DATA;
            DISCARD: state_d = DISCARD;
            default: state_d = IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Output and datapath logic: bit assembly, address load/increment, write strobe.
   always_comb begin
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      addr_hi_d = addr_hi_q;
      addr_d    = addr_q;
      fb_wr_d   = 1'b0;
      fb_addr_d = fb_addr_q;
      fb_data_d = fb_data_q;
      busy_d    = (state_d != IDLE);
      if (state_q == IDLE) begin
         if (ss_fall_s) begin
            bit_cnt_d = 3'd0;
            shift_d   = 7'd0;
         end else begin
            bit_cnt_d = bit_cnt_q;
         end
      end else begin
         if (sclk_rise_s) begin
            shift_d   = byte_s[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
         end else begin
            shift_d   = shift_q;
         end
         // A byte completing in the same cycle as SS rising is still committed.
         if (byte_done_s) begin
            case (state_q)
               ADDR_HI: addr_hi_d = byte_s;
               ADDR_LO: addr_d    = ADDR_W'({addr_hi_q, byte_s});
               DATA: begin
                  fb_wr_d   = 1'b1;
                  fb_addr_d = addr_q;
                  fb_data_d = DATA_W'(byte_s);
                  addr_d    = addr_q + ADDR_ONE;
               end
               default: addr_d = addr_q;
            endcase
         end else begin
            addr_d = addr_q;
         end
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         bit_cnt_q <= 3'd0;
         shift_q   <= 7'd0;
         addr_hi_q <= 8'd0;
         addr_q    <= {ADDR_W{1'b0}};
         fb_wr_q   <= 1'b0;
         fb_addr_q <= {ADDR_W{1'b0}};
         fb_data_q <= {DATA_W{1'b0}};
         busy_q    <= 1'b0;
      end else begin
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         addr_hi_q <= addr_hi_d;
         addr_q    <= addr_d;
         fb_wr_q   <= fb_wr_d;
         fb_addr_q <= fb_addr_d;
         fb_data_q <= fb_data_d;
         busy_q    <= busy_d;
      end
   end

   assign fb_wr_o   = fb_wr_q;
   assign fb_addr_o = fb_addr_q;
   assign fb_data_o = fb_data_q;
   assign busy_o    = busy_q;

`ifdef SPI_PIXEL_RX_STATS_EN
   logic        err_inc_s;
   logic [15:0] err_cnt_q, err_cnt_d;

   // Unknown opcodes and bytes cut short by SS rising count as errors.
   always_comb begin
      err_inc_s = 1'b0;
      if (byte_done_s && (state_q == CMD) && (byte_s != CMD_WRITE)) begin
         err_inc_s = 1'b1;
      end else if (ss_rise_s && !byte_done_s && (bit_cnt_q != 3'd0) &&
                   (state_q != IDLE) && (state_q != DISCARD)) begin
         err_inc_s = 1'b1;
      end else begin
         err_inc_s = 1'b0;
      end
      if (err_inc_s) begin
         err_cnt_d = sat_inc16(err_cnt_q);
      end else begin
         err_cnt_d = err_cnt_q;
      end
   end

   // Error counter register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         err_cnt_q <= 16'd0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_spi_pixel_rx.sv
// Directed bench for spi_pixel_rx: SPI transactions with hand-computed framebuffer writes.
`timescale 1ns/1ps
module tb_spi_pixel_rx;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        spi_sclk_i;
   logic        spi_ss_i;
   logic        spi_mosi_i;
   logic        fb_wr_o;
   logic [15:0] fb_addr_o;
   logic [7:0]  fb_data_o;
   logic        busy_o;
`ifdef SPI_PIXEL_RX_STATS_EN
   logic [15:0] err_cnt_o;
`endif

   spi_pixel_rx #(.ADDR_W(16), .DATA_W(8)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .spi_sclk_i (spi_sclk_i),
      .spi_ss_i   (spi_ss_i),
      .spi_mosi_i (spi_mosi_i),
      .fb_wr_o    (fb_wr_o),
      .fb_addr_o  (fb_addr_o),
      .fb_data_o  (fb_data_o),
      .busy_o     (busy_o)
`ifdef SPI_PIXEL_RX_STATS_EN
      ,
      .err_cnt_o  (err_cnt_o)
`endif
   );

   // 50 MHz system clock.
   always #10 clk_i = ~clk_i;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int wr_long  = 0;
   logic wr_prev = 1'b0;

   logic [15:0] got_addr[$];
   logic [7:0]  got_data[$];
   logic [15:0] exp_addr[$];
   logic [7:0]  exp_data[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Capture every write strobe and flag strobes longer than one cycle.
   always @(negedge clk_i) begin
      if (fb_wr_o) begin
         got_addr.push_back(fb_addr_o);
         got_data.push_back(fb_data_o);
      end
      if (fb_wr_o && wr_prev) wr_long++;
      wr_prev = fb_wr_o;
   end

   // SCLK half period of 4 clk_i cycles gives exactly clk_i/8.
   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         spi_mosi_i = b[i];
         #80;
         spi_sclk_i = 1'b1;
         #80;
         spi_sclk_i = 1'b0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_bits(b, 8);
   endtask

   task automatic ss_begin();
      spi_ss_i = 1'b0;
      #200;
   endtask

   task automatic ss_end();
      #200;
      spi_ss_i = 1'b1;
      #200;
   endtask

   task automatic expect_wr(input logic [15:0] a, input logic [7:0] d);
      exp_addr.push_back(a);
      exp_data.push_back(d);
   endtask

   task automatic compare_writes(input string tag);
      int n;
      check({tag, "_count"}, got_addr.size(), exp_addr.size());
      n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr[i]);
         check($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
      end
      got_addr.delete();
      got_data.delete();
      exp_addr.delete();
      exp_data.delete();
   endtask

   initial begin
      rst_i      = 1'b0;
      spi_sclk_i = 1'b0;
      spi_ss_i   = 1'b1;
      spi_mosi_i = 1'b0;
      #100;
      check("rst_wr",   fb_wr_o,   0);
      check("rst_addr", fb_addr_o, 0);
      check("rst_data", fb_data_o, 0);
      check("rst_busy", busy_o,    0);
      rst_i = 1'b1;
      #200;

      // Basic write of two pixels.
      ss_begin();
      check("t1_busy", busy_o, 1);
      send_byte(8'h01); send_byte(8'h00); send_byte(8'h10);
      send_byte(8'hAA); send_byte(8'hBB);
      ss_end();
      check("t1_idle", busy_o, 0);
      expect_wr(16'h0010, 8'hAA);
      expect_wr(16'h0011, 8'hBB);
      compare_writes("t1");

      // Address wrap at 0xFFFF.
      ss_begin();
      send_byte(8'h01); send_byte(8'hFF); send_byte(8'hFF);
      send_byte(8'h11); send_byte(8'h22);
      ss_end();
      expect_wr(16'hFFFF, 8'h11);
      expect_wr(16'h0000, 8'h22);
      compare_writes("t2");
      check("t2_hold_addr", fb_addr_o, 16'h0000);
      check("t2_hold_data", fb_data_o, 8'h22);

      // Unknown command is discarded.
      ss_begin();
      send_byte(8'h05); send_byte(8'h00); send_byte(8'h00); send_byte(8'h33);
      ss_end();
      compare_writes("t3");
      check("t3_hold_data", fb_data_o, 8'h22);
`ifdef SPI_PIXEL_RX_STATS_EN
      check("t3_err", err_cnt_o, 1);
`endif

      // Partial byte dropped, then a clean transaction.
      ss_begin();
      send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
      send_bits(8'hF0, 4);
      ss_end();
      compare_writes("t4a");
      check("t4_idle", busy_o, 0);
`ifdef SPI_PIXEL_RX_STATS_EN
      check("t4_err", err_cnt_o, 2);
`endif
      ss_begin();
      send_byte(8'h01); send_byte(8'h00); send_byte(8'h02); send_byte(8'h44);
      ss_end();
      expect_wr(16'h0002, 8'h44);
      compare_writes("t4b");

      // Reset mid data byte with SS held low.
      ss_begin();
      send_byte(8'h01); send_byte(8'h00); send_byte(8'h20);
      send_bits(8'h55, 4);
      rst_i = 1'b0;
      #40;
      rst_i = 1'b1;
      send_bits(8'h55, 4);
      send_byte(8'h66);
      #200;
      compare_writes("t5");
      check("t5_addr", fb_addr_o, 0);
      check("t5_data", fb_data_o, 0);
      check("t5_busy", busy_o,    0);
`ifdef SPI_PIXEL_RX_STATS_EN
      check("t5_err", err_cnt_o, 0);
`endif
      ss_end();
      ss_begin();
      send_byte(8'h01); send_byte(8'h00); send_byte(8'h05); send_byte(8'h66);
      ss_end();
      expect_wr(16'h0005, 8'h66);
      compare_writes("t5b");

      // SS rises in the same cycle the 8th bit is sampled: byte still written.
      ss_begin();
      send_byte(8'h01); send_byte(8'h00); send_byte(8'h30);
      send_bits(8'h77, 7);
      spi_mosi_i = 1'b1;
      #80;
      spi_sclk_i = 1'b1;
      spi_ss_i   = 1'b1;
      #80;
      spi_sclk_i = 1'b0;
      #200;
      expect_wr(16'h0030, 8'h77);
      compare_writes("t6");
      check("t6_idle", busy_o, 0);

      // 256-byte burst at SCLK = clk_i/8.
      ss_begin();
      send_byte(8'h01); send_byte(8'h01); send_byte(8'h00);
      for (int i = 0; i < 256; i++) begin
         send_byte(8'(i));
         expect_wr(16'h0100 + 16'(i), 8'(i));
      end
      ss_end();
      compare_writes("t7");

      check("wr_pulse_len", wr_long, 0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
